gpio_irq_ctrl: RTL

Interrupt and input-conditioning engine behind the GPIO register file. It synchronises raw pad inputs and optionally deglitches them. It detects per-pin edge or level events selected by INTTYPE1/INTTYPE0, holds them as sticky INTSTAT bits that clear when INTSTAT is read, and drives the single GPIO irq line. The APB register block instantiates it, feeds it the PADDIR/INTEN/INTTYPE register values, and reads back PADIN and INTSTAT from it.

---
 rtl/gpio_irq_ctrl_if.sv | 29 ++
 rtl/gpio_irq_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/gpio_irq_ctrl_if.sv
// Signal bundle between the GPIO register block (master) and the
// input-conditioning / interrupt engine (slave).
interface gpio_irq_ctrl_if #(
    parameter int GPIO_NUM = 8
);
    logic [GPIO_NUM-1:0] gpio_in_i;
    logic [GPIO_NUM-1:0] dir_i;
    logic [GPIO_NUM-1:0] inten_i;
    logic [GPIO_NUM-1:0] inttype0_i;
    logic [GPIO_NUM-1:0] inttype1_i;
    logic                filt_en_i;
    logic [15:0]         filt_div_i;
    logic                stat_rd_i;
    logic [GPIO_NUM-1:0] gpio_val_o;
    logic [GPIO_NUM-1:0] stat_o;
    logic                irq_o;

    modport master (
        output gpio_in_i, dir_i, inten_i, inttype0_i, inttype1_i,
               filt_en_i, filt_div_i, stat_rd_i,
        input  gpio_val_o, stat_o, irq_o
    );

    modport slave (
        input  gpio_in_i, dir_i, inten_i, inttype0_i, inttype1_i,
               filt_en_i, filt_div_i, stat_rd_i,
        output gpio_val_o, stat_o, irq_o
    );
endinterface

// File: rtl/gpio_irq_ctrl.sv
// GPIO input conditioning (2-flop sync + prescaled deglitch) and sticky
// per-pin edge/level interrupt status driving a single irq line.
module gpio_irq_ctrl #(
    parameter int GPIO_NUM    = 8,
    parameter int FILT_CNT_W  = 4,
    parameter int FILT_THRESH = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    gpio_irq_ctrl_if.slave    bus
);
    localparam logic [FILT_CNT_W-1:0] THRESH_C = FILT_CNT_W'(FILT_THRESH);
    localparam logic [FILT_CNT_W-1:0] CNT_ONE  = {{(FILT_CNT_W-1){1'b0}}, 1'b1};

    logic [GPIO_NUM-1:0] sync1_reg;
    logic [GPIO_NUM-1:0] sync2_reg;
    logic [GPIO_NUM-1:0] filt_vec;
    logic [GPIO_NUM-1:0] prev_reg;
    logic [GPIO_NUM-1:0] stat_reg;
    logic [GPIO_NUM-1:0] stat_next;
    logic [GPIO_NUM-1:0] evt;
    logic [GPIO_NUM-1:0] qual_evt;
    logic [GPIO_NUM-1:0] clr;
    logic                irq_reg;
    logic [15:0]         presc_reg;
    logic [15:0]         presc_next;
    logic                tick;

    // Prescaler: free-runs only while filtering is enabled.
    assign tick = bus.filt_en_i && (presc_reg == bus.filt_div_i);

    always_comb begin
        presc_next = presc_reg + 16'd1;
        if (!bus.filt_en_i || tick) begin
            presc_next = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            presc_reg <= '0;
        end else begin
            sync1_reg <= bus.gpio_in_i;
            sync2_reg <= sync1_reg;
            presc_reg <= presc_next;
        end
    end

    generate
        for (genvar gi = 0; gi < GPIO_NUM; gi++) begin : g_pin
            logic                  filt_bit_reg;
            logic                  filt_bit_next;
            logic [FILT_CNT_W-1:0] cnt_reg;
            logic [FILT_CNT_W-1:0] cnt_next;

            // Disabling the filter snaps to the synced value, so the only
            // edge seen is a genuine difference between filt and input.
            always_comb begin
                filt_bit_next = filt_bit_reg;
                cnt_next      = cnt_reg;
                if (!bus.filt_en_i) begin
                    filt_bit_next = sync2_reg[gi];
                    cnt_next      = '0;
                end else if (sync2_reg[gi] == filt_bit_reg) begin
                    cnt_next = '0;
                end else if (tick) begin
                    if ((cnt_reg + CNT_ONE) == THRESH_C) begin
                        filt_bit_next = sync2_reg[gi];
                        cnt_next      = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    filt_bit_reg <= 1'b0;
                    cnt_reg      <= '0;
                end else begin
                    filt_bit_reg <= filt_bit_next;
                    cnt_reg      <= cnt_next;
                end
            end

            assign filt_vec[gi] = filt_bit_reg;

            always_comb begin
                evt[gi] = 1'b0;
                case ({bus.inttype1_i[gi], bus.inttype0_i[gi]})
                    2'b00:   evt[gi] =  filt_bit_reg & ~prev_reg[gi];
                    2'b01:   evt[gi] = ~filt_bit_reg &  prev_reg[gi];
                    2'b10:   evt[gi] =  filt_bit_reg;
                    default: evt[gi] = ~filt_bit_reg;
                endcase
            end
        end
    endgenerate

    // Disable/output-direction clears first, a new event beats a read clear.
    assign clr       = ~bus.inten_i | bus.dir_i;
    assign qual_evt  = evt & bus.inten_i & ~bus.dir_i;
    assign stat_next = qual_evt | (stat_reg & ~clr & ~{GPIO_NUM{bus.stat_rd_i}});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_reg <= '0;
            stat_reg <= '0;
            irq_reg  <= 1'b0;
        end else begin
            prev_reg <= filt_vec;
            stat_reg <= stat_next;
            irq_reg  <= |stat_reg;
        end
    end

    assign bus.gpio_val_o = filt_vec;
    assign bus.stat_o     = stat_reg;
    assign bus.irq_o      = irq_reg;
endmodule
